mini_alu_seq: RTL

Parametrised, handshaked execution unit that succeeds the single-cycle 4-bit array-multiplier ALU datapath. It accepts one operation and two DATA_WIDTH operands per transaction, executes ADD/SUB/NOP in one cycle and MUL (and optionally DIV) iteratively, one bit per cycle. Results are presented on a valid/ready output port. It sits between the instruction decode/RAM read stage and the RAM write-back/LED register of the mini-CPU.

---
 rtl/mini_alu_seq.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/mini_alu_seq.sv
// Handshaked execution unit: single-cycle ADD/SUB/NOP, iterative shift-add MUL and
// optional restoring DIV (compiled in when MINI_ALU_SEQ_DIV_EN is defined).
module mini_alu_seq #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    iValid,
    output logic                    oReady,
    input  logic [2:0]              iOperation,
    input  logic [DATA_WIDTH-1:0]   iA,
    input  logic [DATA_WIDTH-1:0]   iB,
    output logic                    oValid,
    input  logic                    iReady,
    output logic [2*DATA_WIDTH-1:0] oResult,
    output logic                    oError,
    output logic                    oBusy
);

    localparam int unsigned W  = DATA_WIDTH;
    localparam int unsigned CW = $clog2(DATA_WIDTH) + 1;

    localparam logic [2:0] OpNop = 3'd0;
    localparam logic [2:0] OpAdd = 3'd1;
    localparam logic [2:0] OpSub = 3'd2;
    localparam logic [2:0] OpMul = 3'd3;
`ifdef MINI_ALU_SEQ_DIV_EN
    localparam logic [2:0] OpDiv = 3'd4;
`endif

    typedef enum logic [1:0] {
        StIdle,
        StMulRun,
`ifdef MINI_ALU_SEQ_DIV_EN
        StDivRun,
`endif
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [2*W-1:0]  acc_q, acc_d;
    logic [W-1:0]    opnd_q, opnd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*W-1:0]  result_q, result_d;
    logic            error_q, error_d;

    logic            accept;
    logic            last_iter;
    logic [W:0]      add_w;
    logic [W:0]      sub_w;
    logic [W:0]      mul_sum;
    logic [2*W-1:0]  mul_next;
`ifdef MINI_ALU_SEQ_DIV_EN
    logic [W:0]      div_shift;
    logic [W-1:0]    div_diff;
    logic [2*W-1:0]  div_next;
`endif

    assign oReady    = (state_q == StIdle) && !Reset;
    assign accept    = iValid && oReady;
    assign last_iter = (cnt_q == CW'(W - 1));

    always_comb begin
        add_w    = {1'b0, iA} + {1'b0, iB};
        // Bit W of the wide difference is the borrow (iA < iB).
        sub_w    = {1'b0, iA} - {1'b0, iB};
        // acc holds {partial product high, remaining multiplier bits}; shift right each step.
        mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_sum, acc_q[W-1:1]};
`ifdef MINI_ALU_SEQ_DIV_EN
        // acc holds {remainder, dividend/quotient}; shift left, try subtracting the divisor.
        div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
        div_diff  = div_shift[W-1:0] - opnd_q;
        if (div_shift >= {1'b0, opnd_q}) begin
            div_next = {div_diff, acc_q[W-2:0], 1'b1};
        end else begin
            div_next = {div_shift[W-1:0], acc_q[W-2:0], 1'b0};
        end
`endif
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        error_d  = error_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    cnt_d    = '0;
                    result_d = '0;
                    error_d  = 1'b0;
                    state_d  = StDone;
                    case (iOperation)
                        OpNop: ;
                        OpAdd: result_d = {{(W-1){1'b0}}, add_w};
                        OpSub: result_d = {{(W-1){1'b0}}, sub_w};
                        OpMul: begin
                            acc_d   = {{W{1'b0}}, iB};
                            opnd_d  = iA;
                            state_d = StMulRun;
                        end
`ifdef MINI_ALU_SEQ_DIV_EN
                        OpDiv: begin
                            acc_d   = {{W{1'b0}}, iA};
                            opnd_d  = iB;
                            error_d = (iB == '0);
                            state_d = StDivRun;
                        end
`endif
                        default: error_d = 1'b1;
                    endcase
                end
            end
            StMulRun: begin
                acc_d = mul_next;
                cnt_d = cnt_q + CW'(1);
                if (last_iter) begin
                    result_d = mul_next;
                    state_d  = StDone;
                end
            end
`ifdef MINI_ALU_SEQ_DIV_EN
            StDivRun: begin
                acc_d = div_next;
                cnt_d = cnt_q + CW'(1);
                if (last_iter) begin
                    result_d = div_next;
                    state_d  = StDone;
                end
            end
`endif
            StDone: begin
                if (iReady) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            opnd_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            error_q  <= error_d;
        end
    end

    assign oValid  = (state_q == StDone);
`ifdef MINI_ALU_SEQ_DIV_EN
    assign oBusy   = (state_q == StMulRun) || (state_q == StDivRun);
`else
    assign oBusy   = (state_q == StMulRun);
`endif
    assign oResult = result_q;
    assign oError  = error_q;

endmodule
